linear_upsampler: RTL

//   Linear-interpolating upsampler between the sample FIFO and DAC_DRIVER. Pops one offset-binary

---
 rtl/dac_path_pkg.sv | 26 ++
 rtl/interp_mac.sv | 72 +++++++
 rtl/linear_upsampler.sv | 119 +++++++++++
 3 files changed

// File: rtl/dac_path_pkg.sv
// dac_path_pkg: shared definitions for the DAC output path.
// Holds the upsampler state encoding, the offset-binary midscale helper
// and the legal range for the log2 upsample factor.
package dac_path_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    PRIME2,
    RUN
  } state_e;

  localparam int SAMPLE_RATE_MIN = 1;
  localparam int SAMPLE_RATE_MAX = 8;

  // Offset-binary zero: the code that sits in the middle of the range.
  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

  function automatic bit sample_rate_legal(input int rate);
    return (rate >= SAMPLE_RATE_MIN) && (rate <= SAMPLE_RATE_MAX);
  endfunction

endpackage

// File: rtl/interp_mac.sv
// interp_mac: two-stage multiply/shift/add producing one straight-line point
// y = x0 + ((x1 - x0) * k) / 2^SAMPLE_RATE.
// Build option: LINEAR_UPSAMPLER_ROUND_EN adds half an LSB before the shift
// (round-half-up); without it the arithmetic shift floors. Latency is the same.
module interp_mac
  import dac_path_pkg::*;
#(
  parameter int DATAWIDTH   = 14,
  parameter int SAMPLE_RATE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAWIDTH-1:0]   x0,
  input  logic [DATAWIDTH-1:0]   x1,
  input  logic [SAMPLE_RATE-1:0] k,
  output logic [DATAWIDTH-1:0]   y
);

  localparam int PW = DATAWIDTH + 1 + SAMPLE_RATE;
  localparam logic [DATAWIDTH-1:0] MID = DATAWIDTH'(midscale(DATAWIDTH));
`ifdef LINEAR_UPSAMPLER_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1 << (SAMPLE_RATE - 1));
`endif

  logic signed [DATAWIDTH:0] diff;
  logic signed [PW-1:0]      diff_ext;
  logic signed [PW-1:0]      k_ext;
  logic signed [PW-1:0]      p_d, p_q;
  logic [DATAWIDTH-1:0]      x0_d, x0_q;
  logic signed [PW-1:0]      p_adj;
  logic signed [PW-1:0]      p_shift;
  logic signed [PW-1:0]      x0_ext;
  logic [DATAWIDTH-1:0]      y_d, y_q;

  // Stage 1 inputs: signed slope times phase, x0 carried alongside.
  always_comb begin
    diff     = $signed({1'b0, x1}) - $signed({1'b0, x0});
    diff_ext = PW'(diff);
    k_ext    = PW'($signed({1'b0, k}));
    p_d      = diff_ext * k_ext;
    x0_d     = x0;
  end

  // Stage 2 input: scale the product back down and add it onto x0; the
  // result always lies between the two endpoints so it never wraps.
  always_comb begin
`ifdef LINEAR_UPSAMPLER_ROUND_EN
    p_adj   = p_q + HALF;
`else
    p_adj   = p_q;
`endif
    p_shift = p_adj >>> SAMPLE_RATE;
    x0_ext  = PW'($signed({1'b0, x0_q}));
    y_d     = DATAWIDTH'(x0_ext + p_shift);
  end

  // Pipeline registers; reset parks the output at midscale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q  <= '0;
      x0_q <= MID;
      y_q  <= MID;
    end else begin
      p_q  <= p_d;
      x0_q <= x0_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/linear_upsampler.sv
// linear_upsampler: pops one offset-binary sample per 2^SAMPLE_RATE clocks
// from the sample FIFO and emits one interpolated point per clock.
// Build option: LINEAR_UPSAMPLER_ROUND_EN selects rounding in interp_mac.
module linear_upsampler
  import dac_path_pkg::*;
#(
  parameter int DATAWIDTH   = 14,
  parameter int SAMPLE_RATE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] dataIn,
  output logic                 rd_en,
  output logic [DATAWIDTH-1:0] inter_data,
  output logic                 data_valid,
  output logic                 underrun
);

  localparam logic [DATAWIDTH-1:0]   MID    = DATAWIDTH'(midscale(DATAWIDTH));
  localparam logic [SAMPLE_RATE-1:0] K_POP  = SAMPLE_RATE'((1 << SAMPLE_RATE) - 2);
  localparam logic [SAMPLE_RATE-1:0] K_LAST = SAMPLE_RATE'((1 << SAMPLE_RATE) - 1);

  if (!sample_rate_legal(SAMPLE_RATE)) begin : g_rate_check
    $error("linear_upsampler: SAMPLE_RATE must lie in 1..8");
  end

  state_e                 state_q, state_d;
  logic [SAMPLE_RATE-1:0] k_q, k_d;
  logic [DATAWIDTH-1:0]   x0_q, x0_d;
  logic [DATAWIDTH-1:0]   x1_q, x1_d;
  logic                   popped_q, popped_d;
  logic                   underrun_q, underrun_d;
  logic [1:0]             vld_q, vld_d;

  // Next-state logic: priming pops, then one pop per segment two phases
  // before the segment boundary so the data lands exactly at k = L-1.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    popped_d   = popped_q;
    underrun_d = underrun_q;
    rd_en      = 1'b0;
    vld_d      = {vld_q[0], state_q == RUN};
    case (state_q)
      IDLE: begin
        if (ena && !fifo_empty) state_d = PRIME0;
      end
      PRIME0: begin
        rd_en   = 1'b1;
        state_d = PRIME1;
      end
      PRIME1: begin
        x0_d     = dataIn;
        rd_en    = !fifo_empty;
        popped_d = !fifo_empty;
        state_d  = PRIME2;
      end
      PRIME2: begin
        x1_d    = popped_q ? dataIn : x0_q;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        k_d = k_q + SAMPLE_RATE'(1);
        if (k_q == K_POP) begin
          rd_en    = !fifo_empty;
          popped_d = !fifo_empty;
          if (fifo_empty) underrun_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          x0_d = x1_q;
          if (popped_q) x1_d = dataIn;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and sample registers; reset returns to a quiet midscale output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      x0_q       <= MID;
      x1_q       <= MID;
      popped_q   <= 1'b0;
      underrun_q <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      popped_q   <= popped_d;
      underrun_q <= underrun_d;
      vld_q      <= vld_d;
    end
  end

  interp_mac #(
    .DATAWIDTH  (DATAWIDTH),
    .SAMPLE_RATE(SAMPLE_RATE)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .x0 (x0_q),
    .x1 (x1_q),
    .k  (k_q),
    .y  (inter_data)
  );

  assign data_valid = vld_q[1];
  assign underrun   = underrun_q;

endmodule
